// File: rtl/div_pkg.sv
// Shared types for the divider issue queue: default width, FSM state encoding
// and the operand-pair record held in the queue.
package div_pkg;

  localparam int DIV_WIDTH = 64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_HOLD      = 3'd4
  } div_state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
  } div_pair_t;

endpackage

// File: rtl/div_issue_queue_if.sv
// Bundle of the upstream, divider and downstream signals of div_issue_queue.
// Handshakes: a transfer happens on a rising edge where valid=1 and ready=1;
// valid may not depend on ready; div_valid is a one-cycle start pulse with no ready.
interface div_issue_queue_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH,
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             div_valid;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_vld;
  logic [WIDTH-1:0] div_quotient;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             out_dbz;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_dividend, in_divisor, div_vld, div_quotient, out_ready,
    input  in_ready, div_valid, div_dividend, div_divisor, out_valid, out_quotient,
           out_dbz, count
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, div_vld, div_quotient, out_ready,
    output in_ready, div_valid, div_dividend, div_divisor, out_valid, out_quotient,
           out_dbz, count
  );

endinterface

// File: rtl/div_op_fifo.sv
// Circular operand-pair queue; pointers wrap modulo DEPTH (a power of two).
// A push is never visible at the head in the same cycle it is written.
module div_op_fifo
  import div_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type pair_t = div_pair_t,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          i_push,
  input  logic          i_pop,
  input  pair_t         i_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output pair_t         o_head
);

  localparam int AW = $clog2(DEPTH);

  pair_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: an entry is only read once the count covers it.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/div_issue_queue.sv
// Queues operand pairs and feeds them one at a time to an external divider,
// short-circuiting divide-by-zero and presenting each result until accepted.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst,
  div_issue_queue_if.slave   bus,
  output div_state_t         o_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
  } pair_t;

  div_state_t       r_state;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic             r_dbz;

  pair_t            w_in_pair;
  pair_t            w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_head_dbz;
  logic [CW-1:0]    w_count;

  assign w_in_pair  = '{dividend: bus.in_dividend, divisor: bus.in_divisor};
  assign w_push     = bus.in_valid && bus.in_ready;
  assign w_head_dbz = (w_head.divisor == '0);
  // The head leaves either as it is issued, or straight from IDLE when it is a divide-by-zero.
  assign w_pop      = (r_state == S_ISSUE) ||
                      ((r_state == S_IDLE) && !w_empty && w_head_dbz);

  div_op_fifo #(
    .DEPTH  (DEPTH),
    .pair_t (pair_t)
  ) u_fifo (
    .clk     (clk),
    .arst    (arst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in_pair),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state        <= S_IDLE;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_quotient     <= '0;
      r_dbz          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_head_dbz) begin
              r_quotient <= '1;
              r_dbz      <= 1'b1;
              r_state    <= S_HOLD;
            end else begin
              r_div_dividend <= w_head.dividend;
              r_div_divisor  <= w_head.divisor;
              r_state        <= S_ISSUE;
            end
          end
        end
        S_ISSUE:     r_state <= S_WAIT_CLR;
        // A div_vld still high from the previous job must drop before a result is trusted.
        S_WAIT_CLR:  if (!bus.div_vld) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (bus.div_vld) begin
            r_quotient <= bus.div_quotient;
            r_dbz      <= 1'b0;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD:      if (bus.out_ready) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = !arst && !w_full;
  assign bus.count        = w_count;
  assign bus.div_valid    = (r_state == S_ISSUE);
  assign bus.div_dividend = r_div_dividend;
  assign bus.div_divisor  = r_div_divisor;
  assign bus.out_valid    = (r_state == S_HOLD);
  assign bus.out_quotient = r_quotient;
  assign bus.out_dbz      = r_dbz;
  assign o_state          = r_state;

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed scenarios plus random traffic, with a
// divider model and an in-order result scoreboard.
module tb_div_issue_queue;
  import div_pkg::*;

  localparam int W = 32;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       arst;
  div_state_t dut_state;

  always #5 clk = ~clk;

  div_issue_queue_if #(.WIDTH(W), .DEPTH(D)) bus ();

  div_issue_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .arst    (arst),
    .bus     (bus),
    .o_state (dut_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard: results in push order as {dbz, quotient}; operand pairs expected at the divider.
  logic [W:0]     exp_q [$];
  logic [2*W-1:0] iss_q [$];
  logic [W-1:0]   all_ones;

  // Divider model: after a start it keeps the old div_vld for dv_n cycles, drops it, then
  // raises it with the true quotient and leaves it high until the next start.
  int           dv_phase;
  int           dv_n;
  logic         dv_busy;
  logic [W-1:0] dv_a;
  logic [W-1:0] dv_b;
  int           dv_stale_cfg;
  int           dv_lat_cfg;
  bit           dv_stall;
  int           starts;

  task automatic model_clear();
    exp_q.delete();
    iss_q.delete();
    dv_phase = 0;
    dv_n     = 0;
    dv_busy  = 1'b0;
  endtask

  task automatic cycle();
    logic         s_push, s_start, s_pop, s_hold, s_dbz;
    logic [W-1:0] s_a, s_b, s_da, s_db, s_q;
    logic [W:0]   e;
    logic [2*W-1:0] p;
    s_push  = bus.in_valid && bus.in_ready;
    s_a     = bus.in_dividend;
    s_b     = bus.in_divisor;
    s_start = bus.div_valid;
    s_da    = bus.div_dividend;
    s_db    = bus.div_divisor;
    s_pop   = bus.out_valid && bus.out_ready;
    s_hold  = bus.out_valid && !bus.out_ready;
    s_q     = bus.out_quotient;
    s_dbz   = bus.out_dbz;
    @(posedge clk);
    #1;
    if (!arst) begin
      if (s_start) begin
        starts++;
        check_eq("one_in_flight", dv_busy, 0);
        check_eq("issue_expected", iss_q.size() != 0, 1);
        if (iss_q.size() != 0) begin
          p = iss_q.pop_front();
          check_eq("issue_dividend", s_da, p[2*W-1:W]);
          check_eq("issue_divisor", s_db, p[W-1:0]);
        end
        dv_busy  = 1'b1;
        dv_a     = s_da;
        dv_b     = s_db;
        dv_phase = 1;
        dv_n     = (dv_stale_cfg >= 0) ? dv_stale_cfg : $urandom_range(0, 3);
      end
      if (s_pop) begin
        check_eq("result_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_quotient", s_q, e[W-1:0]);
          check_eq("out_dbz", s_dbz, e[W]);
        end
      end
      if (s_push) begin
        exp_q.push_back((s_b == '0) ? {1'b1, all_ones} : {1'b0, s_a / s_b});
        if (s_b != '0) iss_q.push_back({s_a, s_b});
      end
      if (s_hold) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_quotient", bus.out_quotient, s_q);
        check_eq("hold_dbz", bus.out_dbz, s_dbz);
      end
      if (dv_phase == 1) begin
        if (dv_n <= 0) begin
          bus.div_vld = 1'b0;
          dv_phase    = 2;
          dv_n        = (dv_lat_cfg > 0) ? dv_lat_cfg : $urandom_range(1, 4);
        end else dv_n--;
      end else if (dv_phase == 2) begin
        if (dv_n <= 1) begin
          if (!dv_stall) begin
            bus.div_vld      = 1'b1;
            bus.div_quotient = dv_a / dv_b;
            dv_phase         = 0;
            dv_busy          = 1'b0;
          end
        end else dv_n--;
      end
    end
  endtask

  task automatic push_one(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    for (int n = 0; n < budget && !bus.out_valid; n++) cycle();
    check_eq("wait_out_timeout", bus.out_valid, 1);
  endtask

  task automatic drain(input int budget);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < budget && exp_q.size() != 0; n++) cycle();
    check_eq("drain_empty", exp_q.size(), 0);
    repeat (2) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, bus.in_ready, 0);
    check_eq({tag, "_div_valid"}, bus.div_valid, 0);
    check_eq({tag, "_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_out_dbz"}, bus.out_dbz, 0);
    check_eq({tag, "_out_quotient"}, bus.out_quotient, 0);
    check_eq({tag, "_div_dividend"}, bus.div_dividend, 0);
    check_eq({tag, "_div_divisor"}, bus.div_divisor, 0);
    check_eq({tag, "_count"}, bus.count, 0);
    check_eq({tag, "_state"}, dut_state, S_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, issued, starts0;
    all_ones         = '1;
    arst             = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_dividend  = '0;
    bus.in_divisor   = '0;
    bus.div_vld      = 1'b0;
    bus.div_quotient = '0;
    bus.out_ready    = 1'b0;
    dv_stale_cfg     = 0;
    dv_lat_cfg       = 1;
    dv_stall         = 1'b0;
    starts           = 0;
    model_clear();

    // Reset state
    repeat (3) cycle();
    check_reset_outputs("reset");
    arst = 1'b0;
    #1;
    check_eq("ready_after_reset", bus.in_ready, 1);

    // (100,7) with a stale div_vld left over
    bus.div_vld      = 1'b1;
    bus.div_quotient = 99;
    dv_stale_cfg     = 1;
    dv_lat_cfg       = 2;
    push_one(100, 7);
    check_eq("lat_c1_div_valid", bus.div_valid, 0);
    cycle();
    check_eq("lat_c2_div_valid", bus.div_valid, 1);
    check_eq("lat_c2_dividend", bus.div_dividend, 100);
    check_eq("lat_c2_divisor", bus.div_divisor, 7);
    cycle();
    check_eq("pulse_one_cycle", bus.div_valid, 0);
    wait_out(20);
    check_eq("q100_7_quotient", bus.out_quotient, 14);
    check_eq("q100_7_dbz", bus.out_dbz, 0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check_eq("out_valid_drops", bus.out_valid, 0);

    // Divide by zero
    starts0 = starts;
    push_one(5, 0);
    check_eq("dbz_c1_out_valid", bus.out_valid, 0);
    cycle();
    check_eq("dbz_c2_out_valid", bus.out_valid, 1);
    check_eq("dbz_quotient", bus.out_quotient, {32'd0, all_ones});
    check_eq("dbz_flag", bus.out_dbz, 1);
    repeat (3) begin
      cycle();
      check_eq("dbz_held", bus.out_valid, 1);
    end
    check_eq("dbz_no_issue", starts - starts0, 0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check_eq("dbz_released", bus.out_valid, 0);

    // Fill to DEPTH behind a stalled divider
    dv_stale_cfg = 0;
    dv_lat_cfg   = 1;
    dv_stall     = 1'b1;
    push_one(1000, 10);
    repeat (5) cycle();
    check_eq("fill_start_count", bus.count, 0);
    for (int i = 0; i < D; i++) begin
      push_one(W'(100 * (i + 1)), 5);
      check_eq("fill_count", bus.count, i + 1);
      check_eq("fill_in_ready", bus.in_ready, (i < D - 1) ? 1 : 0);
    end
    push_one(12345, 3);
    check_eq("full_push_ignored", bus.count, D);
    dv_stall      = 1'b0;
    bus.out_ready = 1'b1;
    issued        = 0;
    for (int n = 0; n < 200 && issued < D; n++) begin
      if (bus.div_valid) begin
        c0 = int'(bus.count);
        cycle();
        check_eq("count_dec_on_issue", bus.count, c0 - 1);
        issued++;
      end else cycle();
    end
    check_eq("fill_all_issued", issued, D);
    drain(200);

    // Stale div_vld from the previous job must not be captured
    dv_stale_cfg  = 3;
    dv_lat_cfg    = 2;
    bus.out_ready = 1'b0;
    push_one(900, 3);
    for (int n = 0; n < 20 && !bus.div_valid; n++) cycle();
    check_eq("stale_issue_seen", bus.div_valid, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      check_eq("stale_wait_clr", dut_state, S_WAIT_CLR);
      cycle();
    end
    wait_out(30);
    check_eq("stale_new_quotient", bus.out_quotient, 300);
    drain(50);

    // Simultaneous push and pop with two entries queued
    dv_stale_cfg = 0;
    dv_lat_cfg   = 1;
    dv_stall     = 1'b1;
    push_one(4000, 4);
    repeat (5) cycle();
    push_one(50, 5);
    push_one(60, 6);
    check_eq("pp_preload_count", bus.count, 2);
    dv_stall      = 1'b0;
    bus.out_ready = 1'b1;
    issued        = 0;
    for (int n = 0; n < 400 && issued < 10; n++) begin
      bus.in_valid    = bus.div_valid;
      bus.in_dividend = $urandom;
      bus.in_divisor  = W'($urandom_range(1, 1000));
      if (bus.div_valid) begin
        cycle();
        check_eq("pp_count_stable", bus.count, 2);
        issued++;
      end else cycle();
    end
    bus.in_valid = 1'b0;
    check_eq("pp_jobs", issued, 10);
    drain(300);

    // Reset during WAIT_DONE with two entries queued
    dv_stall      = 1'b1;
    bus.out_ready = 1'b0;
    push_one(700, 7);
    for (int n = 0; n < 20 && dut_state != S_WAIT_DONE; n++) cycle();
    check_eq("rst_in_wait_done", dut_state, S_WAIT_DONE);
    push_one(11, 2);
    push_one(13, 0);
    check_eq("rst_pre_count", bus.count, 2);
    arst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_clear();
    bus.div_vld = 1'b0;
    dv_stall    = 1'b0;
    repeat (2) cycle();
    arst = 1'b0;
    #1;
    check_eq("midrst_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    starts0       = starts;
    repeat (20) begin
      cycle();
      check_eq("midrst_no_out", bus.out_valid, 0);
    end
    check_eq("midrst_no_issue", starts - starts0, 0);

    // Random traffic
    dv_stale_cfg = -1;
    dv_lat_cfg   = -1;
    repeat (400) begin
      bus.in_valid    = ($urandom_range(0, 1) == 1);
      bus.in_dividend = $urandom;
      bus.in_divisor  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 5000));
      bus.out_ready   = ($urandom_range(0, 2) != 0);
      cycle();
    end
    drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
